// File: rtl/quad_eval_driver.sv
// Serial Go/DataIn load initiator for the quadratic evaluator (A*x^2 + B*x + C, 8-bit).
// Define QUAD_EVAL_DRV_CHECK_EN to add the Mismatch self-check output.
module quad_eval_driver #(
   parameter int unsigned GO_HOLD        = 2,
   parameter int unsigned GAP_CYCLES     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic       Clock,
   input  logic       ResetN,
   input  logic       Start,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [7:0] C,
   input  logic [7:0] X,
   output logic       Ready,
   output logic       Go,
   output logic [7:0] DataOut,
   input  logic       ResultValid,
   input  logic [7:0] DataResult,
   output logic [7:0] Result,
   output logic       Done,
   output logic       Timeout
`ifdef QUAD_EVAL_DRV_CHECK_EN
   ,
   output logic       Mismatch
`endif
);

   localparam int unsigned MaxHg  = (GO_HOLD > GAP_CYCLES) ? GO_HOLD : GAP_CYCLES;
   localparam int unsigned MaxCnt = (TIMEOUT_CYCLES > MaxHg) ? TIMEOUT_CYCLES : MaxHg;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);

   localparam logic [CntW-1:0] HoldLast = CntW'(GO_HOLD - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
   localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StHold,
      StGap,
      StWaitRes,
      StFinish
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0][7:0] coef_q, coef_d;
   logic [7:0]      dout_d, res_d;
   logic            tmo_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      coef_d  = coef_q;
      dout_d  = DataOut;
      res_d   = Result;
      tmo_d   = Timeout;
      case (state_q)
         StIdle: begin
            if (Start) begin
               coef_d  = {X, C, B, A};
               tmo_d   = 1'b0;
               idx_d   = 2'd0;
               cnt_d   = '0;
               dout_d  = A;
               state_d = StSetup;
            end
         end
         StSetup: begin
            cnt_d   = '0;
            state_d = StHold;
         end
         StHold: begin
            if (cnt_q == HoldLast) begin
               cnt_d   = '0;
               state_d = StGap;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d = '0;
               if (idx_q == 2'd3) begin
                  state_d = StWaitRes;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  dout_d  = coef_q[idx_q + 2'd1];
                  state_d = StSetup;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWaitRes: begin
            // A result seen on the final counted cycle still wins over the timeout.
            if (ResultValid) begin
               res_d   = DataResult;
               state_d = StFinish;
            end else if (cnt_q == WaitLast) begin
               tmo_d   = 1'b1;
               state_d = StFinish;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         coef_q  <= '0;
         Ready   <= 1'b1;
         Go      <= 1'b0;
         DataOut <= 8'd0;
         Result  <= 8'd0;
         Done    <= 1'b0;
         Timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         coef_q  <= coef_d;
         Ready   <= (state_d == StIdle);
         Go      <= (state_d == StHold);
         DataOut <= dout_d;
         Result  <= res_d;
         Done    <= (state_d == StFinish);
         Timeout <= tmo_d;
      end
   end

`ifdef QUAD_EVAL_DRV_CHECK_EN
   logic [7:0] exp_q, exp_d;

   // Horner form with 8-bit wrap at each step, matching the evaluator.
   assign exp_d = (A * X + B) * X + C;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         exp_q    <= 8'd0;
         Mismatch <= 1'b0;
      end else begin
         if (state_q == StIdle && Start) exp_q <= exp_d;
         if (state_q == StFinish) Mismatch <= !Timeout && (Result != exp_q);
      end
   end
`endif

endmodule

// File: tb/tb_quad_eval_driver.sv
// Self-checking bench for quad_eval_driver: behavioural evaluator/stub, pulse monitor
// and an arithmetic reference model.
module tb_quad_eval_driver;

   localparam int GoHold        = 2;
   localparam int GapCycles     = 1;
   localparam int TimeoutCycles = 15;
   localparam int PerValue      = 1 + GoHold + GapCycles;
   localparam int LoadCycles    = 4 * PerValue;

   logic       Clock = 1'b0;
   logic       ResetN;
   logic       Start;
   logic [7:0] A, B, C, X;
   logic       Ready, Go, Done, Timeout;
   logic [7:0] DataOut, Result;
   logic       ResultValid;
   logic [7:0] DataResult;
`ifdef QUAD_EVAL_DRV_CHECK_EN
   logic       Mismatch;
`endif

   quad_eval_driver #(
      .GO_HOLD        (GoHold),
      .GAP_CYCLES     (GapCycles),
      .TIMEOUT_CYCLES (TimeoutCycles)
   ) u_dut (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .Start       (Start),
      .A           (A),
      .B           (B),
      .C           (C),
      .X           (X),
      .Ready       (Ready),
      .Go          (Go),
      .DataOut     (DataOut),
      .ResultValid (ResultValid),
      .DataResult  (DataResult),
      .Result      (Result),
      .Done        (Done),
      .Timeout     (Timeout)
`ifdef QUAD_EVAL_DRV_CHECK_EN
      ,
      .Mismatch    (Mismatch)
`endif
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] m_result = 8'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] quad_ref(input logic [7:0] a, b, c, x);
      int r;
      r = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
      return 8'(r % 256);
   endfunction

   // Evaluator: mode 0 live, mode 1 never valid, mode 2 valid idles high and answers 0x5A.
   int         ev_mode = 0;
   int         ev_lat  = 1;
   int         ev_n    = 0;
   int         ev_cd   = -1;
   bit         ev_fire;
   logic       ev_go_prev = 1'b0;
   logic [7:0] ev_v[4];
   logic [7:0] ev_t;

   initial begin
      ResultValid = 1'b0;
      DataResult  = 8'hFF;
      forever begin
         @(negedge Clock);
         if (!ResetN) begin
            ev_n        = 0;
            ev_cd       = -1;
            ResultValid = 1'b0;
            DataResult  = 8'hFF;
         end else begin
            ev_fire = 1'b0;
            if (ev_cd > 0) begin
               ev_cd--;
               if (ev_cd == 0) begin
                  ev_fire = 1'b1;
                  ev_cd   = -1;
               end
            end
            if (Go && !ev_go_prev && ev_n < 4) begin
               ev_v[ev_n] = DataOut;
               ev_n++;
            end
            if (!Go && ev_go_prev && ev_n == 4) begin
               ev_n = 0;
               if (ev_mode != 1) ev_cd = ev_lat;
            end
            if (ev_fire) begin
               ev_t        = ev_v[0] * ev_v[3] + ev_v[1];
               ev_t        = ev_t * ev_v[3] + ev_v[2];
               ResultValid = 1'b1;
               DataResult  = (ev_mode == 2) ? 8'h5A : ev_t;
            end else begin
               ResultValid = (ev_mode == 2 && ev_cd < 0);
               DataResult  = 8'hFF;
            end
         end
         ev_go_prev = Go;
      end
   end

   // Go pulse monitor: values at each rise, pulse widths, low gaps, DataOut stability.
   logic [7:0] mon_v[$];
   int         mon_w[$];
   int         mon_gap[$];
   int         mon_unstable = 0;
   int         mon_width    = 0;
   int         mon_low      = 0;
   int         done_cnt     = 0;
   logic [7:0] mon_d        = 8'd0;
   logic       mon_prev     = 1'b0;

   initial begin
      forever begin
         @(negedge Clock);
         if (Done) done_cnt++;
         if (Go && !mon_prev) begin
            if (mon_v.size() > 0) mon_gap.push_back(mon_low);
            mon_v.push_back(DataOut);
            mon_d     = DataOut;
            mon_width = 1;
         end else if (Go) begin
            mon_width++;
            if (DataOut != mon_d) mon_unstable++;
         end else begin
            if (mon_prev) begin
               mon_w.push_back(mon_width);
               mon_low = 0;
            end
            mon_low++;
            if (mon_low <= GapCycles && mon_v.size() > 0 && DataOut != mon_d) mon_unstable++;
         end
         mon_prev = Go;
      end
   end

   task automatic scramble();
      A = 8'($urandom);
      B = 8'($urandom);
      C = 8'($urandom);
      X = 8'($urandom);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50 && !Ready; i++) @(negedge Clock);
      check("ready_wait", 32'(Ready), 1);
   endtask

   task automatic do_req(input logic [7:0] a, b, c, x, input int mode, input int lat,
                         input bit pulse);
      int         p, d, exp_d, bad_w, bad_g;
      bit         exp_to, ready_bad, got_done;
      logic [7:0] exp_res;
      exp_to  = (mode == 1) || (lat > TimeoutCycles + GapCycles - 1);
      exp_res = exp_to ? m_result : ((mode == 2) ? 8'h5A : quad_ref(a, b, c, x));
      exp_d   = exp_to ? LoadCycles + TimeoutCycles : LoadCycles - GapCycles + lat + 1;
      ev_mode = mode;
      ev_lat  = lat;
      wait_ready();
      mon_v.delete();
      mon_w.delete();
      mon_gap.delete();
      mon_unstable = 0;
      done_cnt     = 0;
      A = a; B = b; C = c; X = x;
      Start = 1'b1;
      p = cyc + 1;
      @(negedge Clock);
      Start = 1'b0;
      scramble();
      check("tmo_clr", 32'(Timeout), 0);
      ready_bad = 1'b0;
      got_done  = 1'b0;
      for (int i = 0; i < 100 && !got_done; i++) begin
         if (Ready) ready_bad = 1'b1;
         @(negedge Clock);
         Start = pulse && (cyc == p + PerValue + 1);
         scramble();
         got_done = Done;
      end
      Start = 1'b0;
      d = cyc - p;
      check("done_seen", 32'(got_done), 1);
      check("ready_busy", 32'(ready_bad), 0);
      check("ready_at_done", 32'(Ready), 0);
      check("latency", 32'(d), 32'(exp_d));
      check("result", 32'(Result), 32'(exp_res));
      check("timeout", 32'(Timeout), 32'(exp_to));
      check("pulses", 32'(mon_v.size()), 4);
      if (mon_v.size() == 4)
         check("data_seq", {mon_v[0], mon_v[1], mon_v[2], mon_v[3]}, {a, b, c, x});
      bad_w = (mon_w.size() == 4) ? 0 : 1;
      foreach (mon_w[i]) if (mon_w[i] != GoHold) bad_w++;
      check("go_width", 32'(bad_w), 0);
      bad_g = (mon_gap.size() == 3) ? 0 : 1;
      foreach (mon_gap[i]) if (mon_gap[i] != 1 + GapCycles) bad_g++;
      check("go_gap", 32'(bad_g), 0);
      check("dout_stable", 32'(mon_unstable), 0);
      @(negedge Clock);
      check("ready_after", 32'(Ready), 1);
      check("done_once", 32'(done_cnt), 1);
`ifdef QUAD_EVAL_DRV_CHECK_EN
      check("mismatch", 32'(Mismatch), 32'(!exp_to && (exp_res != quad_ref(a, b, c, x))));
`endif
      m_result = exp_res;
   endtask

   task automatic reset_mid(input int offset, input logic go_pre);
      int p;
      ev_mode = 0;
      ev_lat  = 2;
      wait_ready();
      scramble();
      Start = 1'b1;
      p = cyc + 1;
      @(negedge Clock);
      Start = 1'b0;
      for (int i = 0; i < 40 && cyc < p + offset; i++) @(negedge Clock);
      check("go_pre_rst", 32'(Go), 32'(go_pre));
      #1 ResetN = 1'b0;
      #1;
      check("rst_go", 32'(Go), 0);
      check("rst_ready", 32'(Ready), 1);
      check("rst_dout", 32'(DataOut), 0);
      check("rst_result", 32'(Result), 0);
      check("rst_done", 32'(Done), 0);
      @(negedge Clock);
      @(negedge Clock);
      ResetN   = 1'b1;
      m_result = 8'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ResetN = 1'b1;
      Start  = 1'b0;
      A = 8'd0; B = 8'd0; C = 8'd0; X = 8'd0;
      #2 ResetN = 1'b0;
      #1;
      check("reset_ready", 32'(Ready), 1);
      check("reset_go", 32'(Go), 0);
      check("reset_dout", 32'(DataOut), 0);
      check("reset_result", 32'(Result), 0);
      check("reset_done", 32'(Done), 0);
      check("reset_timeout", 32'(Timeout), 0);
`ifdef QUAD_EVAL_DRV_CHECK_EN
      check("reset_mismatch", 32'(Mismatch), 0);
`endif
      repeat (3) @(negedge Clock);
      ResetN = 1'b1;
      @(negedge Clock);

      do_req(8'd2, 8'd3, 8'd4, 8'd5, 0, 3, 1'b0);
      check("basic_69", 32'(Result), 32'h45);
      do_req(8'd10, 8'd0, 8'd0, 8'd10, 0, 1, 1'b0);
      check("overflow_e8", 32'(Result), 32'hE8);
      do_req(8'd7, 8'd9, 8'd11, 8'd13, 1, 1, 1'b0);
      check("tmo_keeps", 32'(Result), 32'hE8);
      do_req(8'd21, 8'd33, 8'd45, 8'd57, 0, 2, 1'b1);
      reset_mid(3 * PerValue - GapCycles, 1'b0);
      do_req(8'd1, 8'd1, 8'd1, 8'd1, 0, 2, 1'b0);
      check("ones_3", 32'(Result), 3);
      reset_mid(2 * PerValue + 1, 1'b1);
      do_req(8'd3, 8'd5, 8'd7, 8'd9, 2, 4, 1'b0);
      check("early_valid", 32'(Result), 32'h5A);
      do_req(8'd4, 8'd6, 8'd8, 8'd10, 0, TimeoutCycles + GapCycles - 1, 1'b0);
      do_req(8'd5, 8'd7, 8'd9, 8'd11, 0, TimeoutCycles + GapCycles, 1'b0);
      for (int k = 0; k < 10; k++) begin
         do_req(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(GapCycles, TimeoutCycles + 2)),
                1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
